// File: rtl/xregfile_sb_pkg.sv
// rtl/xregfile_sb_pkg.sv - shared constants and index type for the integer register file
package xregfile_sb_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int RV32E_NREG  = 16;
  localparam int RV32I_NREG  = 32;
  localparam int XREG_IW_MAX = $clog2(RV32I_NREG);

  typedef logic [XREG_IW_MAX-1:0] xreg_idx_t;

endpackage

// File: rtl/xregfile_sb_if.sv
// rtl/xregfile_sb_if.sv - read/write/scoreboard bus between issue, writeback and the register file
interface xregfile_sb_if
  import xregfile_sb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = RV32E_NREG,
  parameter int NRP  = 2
) ();

  localparam int IW = $clog2(NREG);

  logic [NRP*IW-1:0]   raddr;
  logic [NRP*XLEN-1:0] rdata;
  logic [NRP-1:0]      rbusy;
  logic                wreq;
  logic [IW-1:0]       windex;
  logic [XLEN-1:0]     wdata;
  logic                wclr;
  logic                sreq;
  logic [IW-1:0]       sindex;
  logic                sfull;
  logic [NREG-1:0]     busy;

  modport master (
    output raddr, wreq, windex, wdata, wclr, sreq, sindex,
    input  rdata, rbusy, sfull, busy
  );

  modport slave (
    input  raddr, wreq, windex, wdata, wclr, sreq, sindex,
    output rdata, rbusy, sfull, busy
  );

endinterface

// File: rtl/xregfile_sb_scoreboard.sv
// rtl/xregfile_sb_scoreboard.sv - pending-write busy vector with clear-bypassed lookups
module xreg_scoreboard
  import xregfile_sb_pkg::*;
#(
  parameter int NREG = RV32E_NREG,
  parameter int NRP  = 2,
  parameter int IW   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NRP*IW-1:0] raddr,
  input  logic              wreq,
  input  logic              wclr,
  input  logic [IW-1:0]     windex,
  input  logic              sreq,
  input  logic [IW-1:0]     sindex,
  output logic [NRP-1:0]    rbusy,
  output logic              sfull,
  output logic [NREG-1:0]   busy
);

  logic            set;
  logic            clr;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_eff;

  assign set = sreq && (sindex != '0);
  assign clr = wreq && wclr && (windex != '0);

  // Bit 0 is never decoded, so busy[0] stays at its reset value of 0.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int i = 1; i < NREG; i++) begin
      set_vec[i] = set && (xreg_idx_t'(sindex) == xreg_idx_t'(i));
      clr_vec[i] = clr && (xreg_idx_t'(windex) == xreg_idx_t'(i));
    end
  end

  // Set is applied after clear so a back-to-back reissue keeps the bit high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q <= '0;
    end else begin
      busy_q <= (busy_q & ~clr_vec) | set_vec;
    end
  end

  assign busy_eff = busy_q & ~clr_vec;
  assign busy     = busy_q;
  assign sfull    = busy_eff[sindex];

  always_comb begin
    rbusy = '0;
    for (int p = 0; p < NRP; p++) begin
      rbusy[p] = busy_eff[raddr[p*IW +: IW]];
    end
  end

endmodule

// File: rtl/xregfile_sb.sv
// rtl/xregfile_sb.sv - parametrised integer register file with read ports, bypass and scoreboard
module xregfile_sb
  import xregfile_sb_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = RV32E_NREG,
  parameter int NRP    = 2,
  parameter int BYPASS = 1,
  localparam int IW    = $clog2(NREG)
) (
  input  logic        clk,
  input  logic        rstn,
  xregfile_sb_if.slave rf
);

  logic [XLEN-1:0]     xr [NREG];
  logic [NRP*XLEN-1:0] rdata_w;

  // Entry 0 is only ever reset, never written, and reads of index 0 are forced to zero anyway.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREG; i++) begin
        xr[i] <= '0;
      end
    end else if (rf.wreq && (rf.windex != '0)) begin
      xr[rf.windex] <= rf.wdata;
    end
  end

  always_comb begin
    rdata_w = '0;
    for (int p = 0; p < NRP; p++) begin
      if (rf.raddr[p*IW +: IW] == '0) begin
        rdata_w[p*XLEN +: XLEN] = '0;
      end else if ((BYPASS != 0) && rf.wreq && (rf.windex == rf.raddr[p*IW +: IW])) begin
        rdata_w[p*XLEN +: XLEN] = rf.wdata;
      end else begin
        rdata_w[p*XLEN +: XLEN] = xr[rf.raddr[p*IW +: IW]];
      end
    end
  end

  assign rf.rdata = rdata_w;

  xreg_scoreboard #(
    .NREG (NREG),
    .NRP  (NRP),
    .IW   (IW)
  ) u_scoreboard (
    .clk    (clk),
    .rstn   (rstn),
    .raddr  (rf.raddr),
    .wreq   (rf.wreq),
    .wclr   (rf.wclr),
    .windex (rf.windex),
    .sreq   (rf.sreq),
    .sindex (rf.sindex),
    .rbusy  (rf.rbusy),
    .sfull  (rf.sfull),
    .busy   (rf.busy)
  );

endmodule

// File: tb/tb_xregfile_sb.sv
// tb/tb_xregfile_sb.sv - bench for xregfile_sb: RV32E with bypass and RV32I without, same stimulus
module tb_xregfile_sb;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wreq, wclr, sreq;
  logic [4:0]  wi, si, r0, r1;
  logic [31:0] wd;
  logic        chk_en = 1'b0;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  // Instance A: 16 registers, bypass on. Instance B: 32 registers, bypass off.
  xregfile_sb_if #(.XLEN(32), .NREG(16), .NRP(2)) ifa ();
  xregfile_sb_if #(.XLEN(32), .NREG(32), .NRP(2)) ifb ();

  assign ifa.raddr  = {r1[3:0], r0[3:0]};
  assign ifa.windex = wi[3:0];
  assign ifa.sindex = si[3:0];
  assign ifa.wreq   = wreq;
  assign ifa.wclr   = wclr;
  assign ifa.wdata  = wd;
  assign ifa.sreq   = sreq;

  assign ifb.raddr  = {r1, r0};
  assign ifb.windex = wi;
  assign ifb.sindex = si;
  assign ifb.wreq   = wreq;
  assign ifb.wclr   = wclr;
  assign ifb.wdata  = wd;
  assign ifb.sreq   = sreq;

  xregfile_sb #(.XLEN(32), .NREG(16), .NRP(2), .BYPASS(1)) dut_a (.clk(clk), .rstn(rstn), .rf(ifa));
  xregfile_sb #(.XLEN(32), .NREG(32), .NRP(2), .BYPASS(0)) dut_b (.clk(clk), .rstn(rstn), .rf(ifb));

  // Architectural model: register contents and pending flags per instance.
  logic [31:0] mx [2][32];
  logic        mb [2][32];

  function automatic logic [4:0] ix(int k, logic [4:0] v);
    return (k == 1) ? v : {1'b0, v[3:0]};
  endfunction

  function automatic logic [31:0] exp_rd(int k, logic [4:0] ra);
    logic [4:0] a = ix(k, ra);
    logic [4:0] w = ix(k, wi);
    if (a == 5'd0) return 32'd0;
    if (k == 0 && wreq && w == a) return wd;
    return mx[k][a];
  endfunction

  function automatic logic exp_rb(int k, logic [4:0] ra);
    logic [4:0] a = ix(k, ra);
    logic [4:0] w = ix(k, wi);
    return mb[k][a] && !(wreq && wclr && w != 5'd0 && w == a);
  endfunction

  function automatic logic exp_sf(int k);
    logic [4:0] s = ix(k, si);
    logic [4:0] w = ix(k, wi);
    return (s != 5'd0) && mb[k][s] && !(wreq && wclr && w != 5'd0 && w == s);
  endfunction

  function automatic logic [31:0] exp_busy(int k);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < ((k == 1) ? 32 : 16); i++) v[i] = mb[k][i];
    return v;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 32; i++) begin
          mx[k][i] <= 32'd0;
          mb[k][i] <= 1'b0;
        end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (wreq && ix(k, wi) != 5'd0) mx[k][ix(k, wi)] <= wd;
        if (wreq && wclr && ix(k, wi) != 5'd0) mb[k][ix(k, wi)] <= 1'b0;
        if (sreq && ix(k, si) != 5'd0) mb[k][ix(k, si)] <= 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a.rdata0", ifa.rdata[31:0],  exp_rd(0, r0));
      chk("a.rdata1", ifa.rdata[63:32], exp_rd(0, r1));
      chk("a.rbusy",  {30'd0, ifa.rbusy}, {30'd0, exp_rb(0, r1), exp_rb(0, r0)});
      chk("a.sfull",  {31'd0, ifa.sfull}, {31'd0, exp_sf(0)});
      chk("a.busy",   {16'd0, ifa.busy},  exp_busy(0));
      chk("b.rdata0", ifb.rdata[31:0],  exp_rd(1, r0));
      chk("b.rdata1", ifb.rdata[63:32], exp_rd(1, r1));
      chk("b.rbusy",  {30'd0, ifb.rbusy}, {30'd0, exp_rb(1, r1), exp_rb(1, r0)});
      chk("b.sfull",  {31'd0, ifb.sfull}, {31'd0, exp_sf(1)});
      chk("b.busy",   ifb.busy,           exp_busy(1));
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic q, input logic c, input logic [4:0] w, input logic [31:0] d,
                     input logic s, input logic [4:0] sx, input logic [4:0] a0, input logic [4:0] a1);
    wreq = q; wclr = c; wi = w; wd = d; sreq = s; si = sx; r0 = a0; r1 = a1;
    #1;
  endtask

  initial begin
    rstn = 1'b1;
    wreq = 0; wclr = 0; wi = 0; wd = 0; sreq = 0; si = 0; r0 = 0; r1 = 0;
    #1 rstn = 1'b0;
    #1 chk_en = 1'b1;
    chk("rst.busy_b", ifb.busy, 32'd0);
    nxt(); nxt();
    rstn = 1'b1;
    for (int i = 0; i < 16; i++) begin
      nxt(); put(0, 0, 0, 0, 0, 0, 5'(i), 5'(i + 16));
    end
    chk("rst.rdata_b1", ifb.rdata[63:32], 32'd0);

    // same-cycle write/read of x5
    nxt(); put(1, 0, 5, 32'hDEADBEEF, 0, 0, 5, 0);
    chk("byp.a", ifa.rdata[31:0], 32'hDEADBEEF);
    chk("nobyp.b_old", ifb.rdata[31:0], 32'd0);
    nxt(); put(0, 0, 0, 0, 0, 0, 5, 0);
    chk("nobyp.b_new", ifb.rdata[31:0], 32'hDEADBEEF);

    // x0 is immutable and never reserved
    nxt(); put(1, 0, 0, 32'h12345678, 1, 0, 0, 0);
    chk("x0.sfull", {31'd0, ifa.sfull}, 32'd0);
    nxt(); put(0, 0, 0, 0, 0, 0, 0, 0);
    chk("x0.rd_a", ifa.rdata[31:0], 32'd0);
    chk("x0.busy_b", ifb.busy, 32'd0);

    // reserve x7, then complete it
    nxt(); put(0, 0, 0, 0, 1, 7, 7, 0);
    nxt(); put(0, 0, 0, 0, 0, 0, 7, 0);
    chk("sb7.busy", {16'd0, ifa.busy}, 32'h0000_0080);
    chk("sb7.rbusy", {30'd0, ifa.rbusy}, 32'd1);
    nxt(); put(1, 1, 7, 32'h55, 0, 0, 7, 0);
    chk("wb7.rbusy_a", {30'd0, ifa.rbusy}, 32'd0);
    chk("wb7.rdata_a", ifa.rdata[31:0], 32'h55);
    chk("wb7.rbusy_b", {30'd0, ifb.rbusy}, 32'd0);
    nxt(); put(0, 0, 0, 0, 0, 0, 7, 0);
    chk("wb7.busy_b", ifb.busy, 32'd0);

    // reissue x9 in the same cycle as its writeback: set wins
    nxt(); put(0, 0, 0, 0, 1, 9, 9, 0);
    nxt(); put(1, 1, 9, 32'h99, 1, 9, 9, 0);
    nxt(); put(0, 0, 0, 0, 0, 0, 9, 0);
    chk("re9.busy", ifb.busy, 32'h0000_0200);
    chk("re9.rdata", ifb.rdata[31:0], 32'h99);

    // directed vectors: plain write to busy reg, idempotent sreq, x31 / x15 alias
    nxt(); put(1, 0, 9, 32'h1234, 0, 0, 9, 9);
    nxt(); put(0, 0, 0, 0, 1, 9, 9, 3);
    nxt(); put(1, 0, 3, 32'hCAFEF00D, 1, 4, 3, 4);
    nxt(); put(1, 1, 4, 32'h0BAD0BAD, 0, 4, 4, 3);
    nxt(); put(1, 0, 31, 32'hA5A5A5A5, 0, 0, 31, 0);
    nxt(); put(0, 0, 0, 0, 1, 31, 0, 0);
    nxt(); put(0, 0, 0, 0, 0, 31, 0, 31);
    chk("x31.rdata1", ifb.rdata[63:32], 32'hA5A5A5A5);
    chk("x31.rbusy1", {30'd0, ifb.rbusy}, 32'd2);
    chk("x31.sfull", {31'd0, ifb.sfull}, 32'd1);
    nxt(); put(1, 1, 31, 32'h5A5A5A5A, 1, 2, 31, 15);
    nxt(); put(0, 0, 0, 0, 0, 2, 2, 31);

    // asynchronous reset mid-run, then a stale writeback
    nxt();
    rstn = 1'b0;
    put(0, 0, 0, 0, 0, 9, 5, 9);
    chk("arst.rdata_a", ifa.rdata[31:0], 32'd0);
    chk("arst.rdata_b", ifb.rdata[63:32], 32'd0);
    chk("arst.busy_a", {16'd0, ifa.busy}, 32'd0);
    chk("arst.busy_b", ifb.busy, 32'd0);
    nxt();
    rstn = 1'b1;
    put(1, 1, 9, 32'h77, 0, 0, 9, 0);
    nxt(); put(0, 0, 0, 0, 0, 0, 9, 5);
    chk("late.rdata", ifb.rdata[31:0], 32'h77);
    chk("late.busy", ifb.busy, 32'd0);
    nxt(); nxt();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/xregfile_sb.md
Name: xregfile_sb

Overview:
- Parametrised successor of the core's integer register file.
- Supports a configurable register count (RV32E 16 / RV32I 32) and XLEN, plus NRP combinational read ports with optional write-to-read bypass.
- Adds a per-register pending-write scoreboard, so long-latency ops (loads, mul/div) can mark a destination busy at issue and clear it at writeback.
- Sits between the decode/issue stage and the writeback mux; it replaces the flat x[] array export with indexed read ports.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 16, number of architectural registers (16 or 32); x0 is always hardwired zero.
- NRP, 2, number of read ports.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports.
- IW, $clog2(NREG), index width (derived; must not be overridden).

Ports:
- clk  in  1  core clock
- rstn  in  1  asynchronous active-low reset
- raddr  in  NRP*IW  read indices, port p at bits [p*IW +: IW]
- rdata  out  NRP*XLEN  read data, port p at bits [p*XLEN +: XLEN]
- rbusy  out  NRP  port p's register has a pending write
- wreq  in  1  write request
- windex  in  IW  write index
- wdata  in  XLEN  write data
- wclr  in  1  this write completes a scoreboarded op; clear busy[windex]
- sreq  in  1  issue of a long-latency op; set busy[sindex]
- sindex  in  IW  destination being reserved
- sfull  out  1  busy[sindex] already set (WAW hazard; issue must stall)
- busy  out  NREG  raw scoreboard vector, bit 0 always 0

Behaviour:
- Reset (rstn low, async): all registers 1..NREG-1 = 0; busy = 0. rdata reads 0 for every index.
- x0: reads return 0. Writes to index 0 are ignored. sreq with sindex 0 is ignored; busy[0] is constant 0.
- Write: on posedge clk with wreq && windex!=0, xr[windex] <= wdata. One write port only.
- Read: combinational, zero latency. rdata[p] = 0 if raddr[p]==0, else xr[raddr[p]].
- Bypass, BYPASS=1: if wreq && windex==raddr[p] && windex!=0, rdata[p]=wdata in the same cycle.
- Bypass, BYPASS=0: the new value is visible from the cycle after the write.
- Scoreboard update at posedge clk:
  - set = sreq && sindex!=0
  - clr = wreq && wclr && windex!=0
  - busy[i] <= (busy[i] & ~(clr && windex==i)) | (set && sindex==i)
- Simultaneous set and clear of the same index: set wins, so busy stays 1. This is a back-to-back reissue to the same rd.
- wreq without wclr: writes data and leaves busy unchanged. This is a normal short-latency write to a non-busy register. Writing a busy register without wclr is a protocol error; the data is still written.
- rbusy[p] = busy[raddr[p]], with the clear bypassed: it reads 0 if this cycle's clr targets raddr[p]. It is never bypassed for set.
- sfull = busy[sindex] && sindex!=0, also with the same-cycle clear bypassed. The issuer must hold sreq low while sfull is high. If sreq is asserted with sfull high, busy stays 1 (idempotent).
- Reset mid-operation: busy and data clear immediately. Any in-flight writeback arriving after reset writes data. Its wclr against a clear bit leaves the bit 0.
- Out-of-range index (NREG=16 with an IW overflow): not possible by construction, because IW is derived.

Decomposition:
- Shared core package: XLEN default, the register-count constants RV32E_NREG=16 and RV32I_NREG=32, and a typedef for the register index.
- One sub-module, xreg_scoreboard: the busy vector, set/clear logic and the rbusy/sfull lookups. It is instantiated once.
- Data storage and bypass muxes stay in the top.

Test Plan:
- Reset, then read all indices on both ports -> rdata=0 and busy=0. Assert rstn low mid-run after writes -> all 0 asynchronously, before the next clk edge.
- Write x5=0xDEADBEEF with raddr0=5 in the same cycle -> BYPASS=1 gives rdata0=0xDEADBEEF that cycle; BYPASS=0 gives the old value, then 0xDEADBEEF next cycle.
- Write x0=0x12345678, then read x0 -> 0. sreq with sindex=0 -> busy[0] stays 0 and sfull=0.
- sreq sindex=7 -> next cycle busy[7]=1 and rbusy0=1 with raddr0=7. Then wreq/wclr windex=7 wdata=0x55 -> rbusy0=0 and rdata0=0x55 in the same cycle; busy[7]=0 the next cycle.
- Same cycle: wreq/wclr windex=9 and sreq sindex=9 (x9 busy) -> busy[9] remains 1 and x9 holds the new data.
- NREG=32 build: write x31=0xA5A5A5A5 and set busy[31], port1 reads 31 -> rdata1=0xA5A5A5A5, rbusy1=1, and sfull=1 for sindex=31.
